stepper_pulse_gen: RTL and testbench

Consumes the (x, y) point stream produced by the line generator and converts it into step/direction pulse trains for the X and Y stepper drivers. The line generator emits one point per clock and has no back-pressure, so a point FIFO absorbs each burst. A step sequencer then drains the FIFO, moving each axis one step per step period until the tracked position equals the target point.

---
 rtl/stepper_pulse_gen.sv | 273 +++++++++++++++++++++++++++
 tb/tb_stepper_pulse_gen.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stepper_pulse_gen.sv
// stepper_pulse_gen
// Buffers (x, y) points from the line generator in a small FIFO and turns
// each point into step/direction pulse trains for two stepper drivers.
// Each step period is DIR_SETUP -> PULSE -> HOLD. Both axes step in
// lockstep until the tracked position equals the target point.

module stepper_pulse_gen #(
  parameter int P_X_COORD_W   = 11,
  parameter int P_Y_COORD_W   = 11,
  parameter int P_FIFO_DEPTH  = 16,
  parameter int P_DIR_SETUP   = 2,
  parameter int P_PULSE_W     = 4,
  parameter int P_STEP_PERIOD = 16
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic [P_X_COORD_W-1:0]          i_x_val,
  input  logic [P_Y_COORD_W-1:0]          i_y_val,
  input  logic                            i_vals_rdy,
  input  logic                            i_set_pos,
  input  logic [P_X_COORD_W-1:0]          i_x_pos,
  input  logic [P_Y_COORD_W-1:0]          i_y_pos,
  output logic                            o_x_step,
  output logic                            o_y_step,
  output logic                            o_x_dir,
  output logic                            o_y_dir,
  output logic [P_X_COORD_W-1:0]          o_x_pos,
  output logic [P_Y_COORD_W-1:0]          o_y_pos,
  output logic [$clog2(P_FIFO_DEPTH):0]   o_fifo_level,
  output logic                            o_overflow,
  output logic                            o_idle
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  localparam int AW       = $clog2(P_FIFO_DEPTH);
  localparam int PT_W     = P_X_COORD_W + P_Y_COORD_W;
  localparam int HOLD_CYC = P_STEP_PERIOD - P_DIR_SETUP - P_PULSE_W;
  localparam int CNT_W    = $clog2(P_STEP_PERIOD + 1);

  // Phase counters are loaded with (length - 1) and count down to zero.
  localparam logic [CNT_W-1:0]       DIR_LAST   = CNT_W'(P_DIR_SETUP - 1);
  localparam logic [CNT_W-1:0]       PULSE_LAST = CNT_W'(P_PULSE_W - 1);
  localparam logic [CNT_W-1:0]       HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
  localparam logic [AW-1:0]          PTR_ONE    = AW'(1);
  localparam logic [AW:0]            LVL_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]            LVL_FULL   = (AW + 1)'(P_FIFO_DEPTH);
  localparam logic [P_X_COORD_W-1:0] X_ONE      = P_X_COORD_W'(1);
  localparam logic [P_Y_COORD_W-1:0] Y_ONE      = P_Y_COORD_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIR_SETUP,
    S_PULSE,
    S_HOLD
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers and next-state values
  // ---------------------------------------------------------------------------
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [PT_W-1:0]         mem_q [P_FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             level_q, level_d;
  logic                    overflow_q, overflow_d;

  logic [P_X_COORD_W-1:0]  pos_x_q, pos_x_d;
  logic [P_Y_COORD_W-1:0]  pos_y_q, pos_y_d;
  logic [P_X_COORD_W-1:0]  tgt_x_q, tgt_x_d;
  logic [P_Y_COORD_W-1:0]  tgt_y_q, tgt_y_d;
  logic                    need_x_q, need_x_d;
  logic                    need_y_q, need_y_d;
  logic                    dir_x_q, dir_x_d;
  logic                    dir_y_q, dir_y_d;
  logic                    step_x_q, step_x_d;
  logic                    step_y_q, step_y_d;
  logic                    idle_q, idle_d;

  logic                    pop;
  logic                    push_acc;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic [P_X_COORD_W-1:0]  head_x;
  logic [P_Y_COORD_W-1:0]  head_y;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_FULL);
  assign head_x     = mem_q[rd_ptr_q][P_X_COORD_W-1:0];
  assign head_y     = mem_q[rd_ptr_q][PT_W-1:P_X_COORD_W];

  // ---------------------------------------------------------------------------
  // FIFO pointer, level and overflow bookkeeping
  // ---------------------------------------------------------------------------
  // A full FIFO still accepts a push when the same cycle pops, so the level
  // is unchanged and nothing is lost.
  always_comb begin
    // NOTE: every signal driven here gets a default first so that no path
    // through the block leaves it unassigned, which would infer a latch.
    push_acc   = i_vals_rdy && (!fifo_full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;

    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (push_acc && !pop)      level_d = level_q + LVL_ONE;
    else if (!push_acc && pop) level_d = level_q - LVL_ONE;

    if (i_vals_rdy && !push_acc) overflow_d = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Step sequencer: next state, counters, position and target tracking
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    tgt_x_d  = tgt_x_q;
    tgt_y_d  = tgt_y_q;
    need_x_d = need_x_q;
    need_y_d = need_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    pop      = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Loading the position wins over starting a new point.
        if (i_set_pos) begin
          pos_x_d = i_x_pos;
          pos_y_d = i_y_pos;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          tgt_x_d = head_x;
          tgt_y_d = head_y;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        // Direction is only ever changed here, while both steps are low.
        need_x_d = (tgt_x_q != pos_x_q);
        need_y_d = (tgt_y_q != pos_y_q);
        dir_x_d  = (tgt_x_q > pos_x_q);
        dir_y_d  = (tgt_y_q > pos_y_q);
        if (!need_x_d && !need_y_d) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DIR_SETUP;
          cnt_d   = DIR_LAST;
        end
      end

      S_DIR_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_PULSE;
          cnt_d   = PULSE_LAST;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_PULSE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LAST;
          // The position moves one step toward the target as HOLD begins.
          if (need_x_q) pos_x_d = dir_x_q ? pos_x_q + X_ONE : pos_x_q - X_ONE;
          if (need_y_q) pos_y_d = dir_y_q ? pos_y_q + Y_ONE : pos_y_q - Y_ONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_HOLD: begin
        if (cnt_q == '0) begin
          if ((pos_x_q == tgt_x_q) && (pos_y_q == tgt_y_q)) state_d = S_IDLE;
          else                                              state_d = S_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered output values, computed one cycle ahead
  // ---------------------------------------------------------------------------
  // Steps are high exactly while the sequencer sits in PULSE; o_idle lags the
  // state by one cycle and drops as soon as a point is pushed.
  always_comb begin
    step_x_d = (state_d == S_PULSE) && need_x_q;
    step_y_d = (state_d == S_PULSE) && need_y_q;
    idle_d   = (state_q == S_IDLE) && fifo_empty && !push_acc;
  end

  // ---------------------------------------------------------------------------
  // State register with synchronous reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      tgt_x_q    <= '0;
      tgt_y_q    <= '0;
      need_x_q   <= 1'b0;
      need_y_q   <= 1'b0;
      dir_x_q    <= 1'b0;
      dir_y_q    <= 1'b0;
      step_x_q   <= 1'b0;
      step_y_q   <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      tgt_x_q    <= tgt_x_d;
      tgt_y_q    <= tgt_y_d;
      need_x_q   <= need_x_d;
      need_y_q   <= need_y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      step_x_q   <= step_x_d;
      step_y_q   <= step_y_d;
      idle_q     <= idle_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Point storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; resetting the pointers and level
  // empties the FIFO, and an entry is never read before it is written.
  always_ff @(posedge i_clk) begin
    if (push_acc) mem_q[wr_ptr_q] <= {i_y_val, i_x_val};
  end

  assign o_x_step     = step_x_q;
  assign o_y_step     = step_y_q;
  assign o_x_dir      = dir_x_q;
  assign o_y_dir      = dir_y_q;
  assign o_x_pos      = pos_x_q;
  assign o_y_pos      = pos_y_q;
  assign o_fifo_level = level_q;
  assign o_overflow   = overflow_q;
  assign o_idle       = idle_q;

endmodule

// File: tb/tb_stepper_pulse_gen.sv
// tb_stepper_pulse_gen
// Scoreboarded bench: the stimulus side turns every accepted point into the
// list of step events it must cause; a negedge monitor consumes those events
// as step pulses appear on the outputs.

module tb_stepper_pulse_gen;

  localparam int XW    = 11;
  localparam int YW    = 11;
  localparam int DEPTH = 16;
  localparam int DS    = 2;
  localparam int PW    = 4;
  localparam int SP    = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          i_clk;
  logic          i_reset;
  logic [XW-1:0] i_x_val;
  logic [YW-1:0] i_y_val;
  logic          i_vals_rdy;
  logic          i_set_pos;
  logic [XW-1:0] i_x_pos;
  logic [YW-1:0] i_y_pos;
  logic          o_x_step, o_y_step, o_x_dir, o_y_dir;
  logic [XW-1:0] o_x_pos;
  logic [YW-1:0] o_y_pos;
  logic [LW-1:0] o_fifo_level;
  logic          o_overflow, o_idle;

  stepper_pulse_gen #(
    .P_X_COORD_W(XW), .P_Y_COORD_W(YW), .P_FIFO_DEPTH(DEPTH),
    .P_DIR_SETUP(DS), .P_PULSE_W(PW), .P_STEP_PERIOD(SP)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_x_val(i_x_val), .i_y_val(i_y_val), .i_vals_rdy(i_vals_rdy),
    .i_set_pos(i_set_pos), .i_x_pos(i_x_pos), .i_y_pos(i_y_pos),
    .o_x_step(o_x_step), .o_y_step(o_y_step),
    .o_x_dir(o_x_dir), .o_y_dir(o_y_dir),
    .o_x_pos(o_x_pos), .o_y_pos(o_y_pos),
    .o_fifo_level(o_fifo_level), .o_overflow(o_overflow), .o_idle(o_idle)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc = cyc + 1;

  // One expected step event: which axes pulse, their directions, and the
  // position the DUT must show once the pulse ends.
  typedef struct {
    bit xs;
    bit ys;
    bit dx;
    bit dy;
    int px;
    int py;
  } ev_t;

  ev_t exp_q[$];
  int  rise_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  mx = 0;
  int  my = 0;
  int  nx = 0;
  int  ny = 0;
  int  peak = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: walk the model position toward the target one step per
  // period, each axis moving by at most one until it matches.
  task automatic model_point(input int x, input int y);
    ev_t e;
    while (mx != x || my != y) begin
      e.xs = (mx != x);
      e.ys = (my != y);
      e.dx = (x > mx);
      e.dy = (y > my);
      if (x > mx) mx++; else if (x < mx) mx--;
      if (y > my) my++; else if (y < my) my--;
      e.px = mx;
      e.py = my;
      exp_q.push_back(e);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: matches every step pulse against the expected event queue.
  // ---------------------------------------------------------------------------
  logic [1:0] prev_st = 2'b00;
  logic [1:0] st_now;
  int         width = 0;
  bit         have_e = 0;
  ev_t        cur_e;

  always @(negedge i_clk) begin
    st_now = {o_x_step, o_y_step};
    if (int'(o_fifo_level) > peak) peak = int'(o_fifo_level);
    if (i_reset) begin
      prev_st = 2'b00;
      have_e  = 0;
      width   = 0;
    end else begin
      if (st_now != 2'b00 && prev_st == 2'b00) begin
        rise_q.push_back(cyc);
        if (o_x_step) nx++;
        if (o_y_step) ny++;
        width = 1;
        check("step_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          cur_e  = exp_q.pop_front();
          have_e = 1;
          check("x_step_axis", o_x_step, cur_e.xs);
          check("y_step_axis", o_y_step, cur_e.ys);
          check("x_dir", o_x_dir, cur_e.dx);
          check("y_dir", o_y_dir, cur_e.dy);
        end
      end else if (st_now != 2'b00) begin
        width++;
        check("lockstep", st_now, prev_st);
      end else if (prev_st != 2'b00) begin
        check("pulse_width", width, PW);
        if (have_e) begin
          check("x_pos_after_step", o_x_pos, cur_e.px);
          check("y_pos_after_step", o_y_pos, cur_e.py);
          check("x_dir_stable", o_x_dir, cur_e.dx);
          check("y_dir_stable", o_y_dir, cur_e.dy);
          have_e = 0;
        end
      end
      prev_st = st_now;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive_point(input int x, input int y);
    @(posedge i_clk); #1;
    i_vals_rdy = 1'b1;
    i_x_val    = XW'(x);
    i_y_val    = YW'(y);
  endtask

  task automatic idle_inputs();
    @(posedge i_clk); #1;
    i_vals_rdy = 1'b0;
    i_set_pos  = 1'b0;
  endtask

  task automatic set_pos(input int x, input int y);
    @(posedge i_clk); #1;
    i_set_pos = 1'b1;
    i_x_pos   = XW'(x);
    i_y_pos   = YW'(y);
    @(posedge i_clk); #1;
    i_set_pos = 1'b0;
    mx = x;
    my = y;
    @(negedge i_clk);
    check("set_pos_x", o_x_pos, x);
    check("set_pos_y", o_y_pos, y);
  endtask

  task automatic wait_idle(input int budget);
    int got = 0;
    repeat (3) @(negedge i_clk);
    for (int i = 0; i < budget && got == 0; i++) begin
      @(negedge i_clk);
      if (o_idle) got = 1;
    end
    check("idle_reached", got, 1);
  endtask

  task automatic wait_step(input int budget);
    int got = 0;
    for (int i = 0; i < budget && got == 0; i++) begin
      @(negedge i_clk);
      if (o_x_step || o_y_step) got = 1;
    end
    check("step_reached", got, 1);
  endtask

  task automatic check_end(input string tag);
    check({tag, "_pos_x"}, o_x_pos, mx);
    check({tag, "_pos_y"}, o_y_pos, my);
    check({tag, "_events_left"}, exp_q.size(), 0);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    i_reset    = 1'b1;
    i_vals_rdy = 1'b0;
    i_set_pos  = 1'b0;
    i_x_val    = '0;
    i_y_val    = '0;
    i_x_pos    = '0;
    i_y_pos    = '0;
    repeat (2) @(posedge i_clk);
    #1 i_reset = 1'b0;

    // Reset state
    @(negedge i_clk);
    check("rst_x_step", o_x_step, 0);
    check("rst_y_step", o_y_step, 0);
    check("rst_x_dir", o_x_dir, 0);
    check("rst_x_pos", o_x_pos, 0);
    check("rst_y_pos", o_y_pos, 0);
    check("rst_level", o_fifo_level, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_idle", o_idle, 1);

    // Single point (1,0): cycle-exact timing of one step period
    drive_point(1, 0);
    model_point(1, 0);
    for (int k = 0; k <= 20; k++) begin
      @(negedge i_clk);
      check("t1_x_dir", o_x_dir, int'(k >= 3));
      check("t1_x_step", o_x_step, int'(k >= 5 && k <= 8));
      check("t1_y_step", o_y_step, 0);
      check("t1_x_pos", o_x_pos, int'(k >= 9));
      if (k == 0 || k == 20)       check("t1_idle_hi", o_idle, 1);
      else if (k >= 1 && k <= 18)  check("t1_idle_lo", o_idle, 0);
      if (k == 0) check("t1_level0", o_fifo_level, 0);
      if (k == 1) check("t1_level1", o_fifo_level, 1);
      if (k == 2) check("t1_level2", o_fifo_level, 0);
      @(posedge i_clk); #1;
      i_vals_rdy = 1'b0;
    end
    check_end("t1");

    // 11-point line from (0,0), pushed on consecutive cycles
    set_pos(0, 0);
    nx = 0;
    ny = 0;
    for (int i = 0; i <= 10; i++) begin
      drive_point((i + 1) / 2, i);
      model_point((i + 1) / 2, i);
    end
    idle_inputs();
    wait_idle(1000);
    check("t2_x_pulses", nx, 5);
    check("t2_y_pulses", ny, 10);
    check("t2_overflow", o_overflow, 0);
    check_end("t2");

    // Multi-step point (3,0): step period via LOAD is SP+1
    set_pos(0, 0);
    rise_q.delete();
    drive_point(3, 0);
    model_point(3, 0);
    idle_inputs();
    wait_idle(500);
    check("t3_rises", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      check("t3_gap1", rise_q[1] - rise_q[0], SP + 1);
      check("t3_gap2", rise_q[2] - rise_q[1], SP + 1);
    end
    check_end("t3");

    // Decreasing move; a position load during PULSE must be ignored
    set_pos(10, 10);
    drive_point(8, 10);
    model_point(8, 10);
    idle_inputs();
    wait_step(100);
    @(posedge i_clk); #1;
    i_set_pos = 1'b1;
    i_x_pos   = '0;
    i_y_pos   = '0;
    idle_inputs();
    wait_idle(500);
    check_end("t4");

    // Top of the coordinate range: x steps up to the maximum, y down to zero
    set_pos(2046, 1);
    drive_point(2047, 0);
    model_point(2047, 0);
    idle_inputs();
    wait_idle(200);
    check_end("edge");

    // Random bursts with random gaps, never enough to fill the FIFO
    for (int b = 0; b < 6; b++) begin
      int n;
      set_pos(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) begin
        int px, py, gap;
        gap = int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) idle_inputs();
        px = int'($urandom_range(0, 7));
        py = int'($urandom_range(0, 7));
        drive_point(px, py);
        model_point(px, py);
      end
      idle_inputs();
      wait_idle(3000);
      check_end("rand");
    end
    check("pre_t5_overflow", o_overflow, 0);

    // 20 back-to-back single-step points into a 16-deep FIFO. Acceptance is
    // derived from the pop timing: first pop one cycle after the first push,
    // the next one a full point period (SP+2) later.
    begin
      int occ;
      int exp_peak;
      bit acc[20];
      occ      = 0;
      exp_peak = 0;
      for (int c = 0; c < 20; c++) begin
        bit p;
        p      = (c == 1 || c == 1 + SP + 2) && (occ > 0);
        acc[c] = (occ < DEPTH) || p;
        occ    = occ + int'(acc[c]) - int'(p);
        if (occ > exp_peak) exp_peak = occ;
      end
      set_pos(0, 0);
      peak = 0;
      for (int i = 0; i < 20; i++) begin
        drive_point(i + 1, 0);
        if (acc[i]) model_point(i + 1, 0);
      end
      idle_inputs();
      @(negedge i_clk);
      check("t5_overflow_set", o_overflow, 1);
      wait_idle(2000);
      check("t5_peak", peak, exp_peak);
      check("t5_overflow_sticky", o_overflow, 1);
      check_end("t5");
    end

    // Reset in the middle of a pulse, then a normal point
    set_pos(0, 0);
    drive_point(2, 3);
    model_point(2, 3);
    drive_point(1, 1);
    idle_inputs();
    wait_step(100);
    @(posedge i_clk); #1;
    i_reset = 1'b1;
    exp_q.delete();
    mx = 0;
    my = 0;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    @(negedge i_clk);
    check("t6_x_step", o_x_step, 0);
    check("t6_y_step", o_y_step, 0);
    check("t6_x_dir", o_x_dir, 0);
    check("t6_y_dir", o_y_dir, 0);
    check("t6_x_pos", o_x_pos, 0);
    check("t6_y_pos", o_y_pos, 0);
    check("t6_level", o_fifo_level, 0);
    check("t6_overflow", o_overflow, 0);
    check("t6_idle", o_idle, 1);
    drive_point(1, 2);
    model_point(1, 2);
    idle_inputs();
    wait_idle(500);
    check_end("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
